// File: rtl/mul.sv
// Single-cycle IEEE-754 binary32 multiplier with a registered result.
// Subnormal inputs read as zero and results that underflow flush to zero.
// Every NaN result is the canonical quiet NaN. round_cfg picks the rounding
// mode for finite results: 0 = round to nearest even, 1 = truncate.
module mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        round_cfg,
    input  logic [31:0] flout_a,
    input  logic [31:0] flout_b,
    output logic [31:0] flout_c
);

    logic        sign_a, sign_b, sign_c;
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;

    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

    logic [23:0]       mant_a, mant_b;
    logic [47:0]       prod;
    logic signed [9:0] exp_sum;

    logic [22:0]       kept;
    logic              guard, rnd, sticky;
    logic signed [9:0] exp_norm;

    logic              round_up;
    logic [23:0]       rounded;
    logic signed [9:0] exp_final;
    logic [22:0]       frac_final;

    logic [31:0] next_c;

    assign sign_a = flout_a[31];
    assign sign_b = flout_b[31];
    assign exp_a  = flout_a[30:23];
    assign exp_b  = flout_b[30:23];
    assign frac_a = flout_a[22:0];
    assign frac_b = flout_b[22:0];
    assign sign_c = sign_a ^ sign_b;

    // An exponent field of zero covers true zero and also subnormals, which are read as zero.
    assign zero_a = (exp_a == 8'h00);
    assign zero_b = (exp_b == 8'h00);
    assign inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
    assign inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
    assign nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
    assign nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);

    // Form the full product of the two significands, each with its hidden one.
    // The exponent is kept signed and 10 bits wide, so both overflow and
    // underflow can be seen after normalization and rounding.
    assign mant_a  = {1'b1, frac_a};
    assign mant_b  = {1'b1, frac_b};
    assign prod    = 48'(mant_a) * 48'(mant_b);
    assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;

    // Normalize the product to 1.x and split off the guard, round and sticky bits.
    always_comb begin
        kept     = prod[45:23];
        guard    = prod[22];
        rnd      = prod[21];
        sticky   = |prod[20:0];
        exp_norm = exp_sum;
        if (prod[47]) begin
            kept     = prod[46:24];
            guard    = prod[23];
            rnd      = prod[22];
            sticky   = |prod[21:0];
            exp_norm = exp_sum + 10'sd1;
        end
    end

    // Round to nearest even, or truncate.
    // A carry out of the fraction moves the result to 1.0 at the next exponent.
    assign round_up   = ~round_cfg & guard & (rnd | sticky | kept[0]);
    assign rounded    = {1'b0, kept} + {23'd0, round_up};
    assign exp_final  = rounded[23] ? (exp_norm + 10'sd1) : exp_norm;
    assign frac_final = rounded[23] ? 23'd0 : rounded[22:0];

    // Special operands take priority.
    // After them, finite results that overflow or underflow are clamped.
    always_comb begin
        next_c = {sign_c, exp_final[7:0], frac_final};
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            next_c = 32'h7FC00000;
        end else if (inf_a || inf_b) begin
            next_c = {sign_c, 8'hFF, 23'd0};
        end else if (zero_a || zero_b) begin
            next_c = {sign_c, 31'd0};
        end else if (exp_final >= 10'sd255) begin
            next_c = round_cfg ? {sign_c, 8'hFE, 23'h7FFFFF} : {sign_c, 8'hFF, 23'd0};
        end else if (exp_final <= 10'sd0) begin
            next_c = {sign_c, 31'd0};
        end
    end

    // The result register loads on each enabled edge. Reset clears it at any time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flout_c <= 32'h00000000;
        end else if (en) begin
            flout_c <= next_c;
        end
    end

endmodule

// File: tb/tb_mul.sv
// Testbench for mul: directed corner cases, an enable/reset stream and a
// randomized regression against an arithmetic reference model.
module tb_mul;

    logic        clk;
    logic        rst;
    logic        en;
    logic        round_cfg;
    logic [31:0] flout_a;
    logic [31:0] flout_b;
    logic [31:0] flout_c;

    int          vectors;
    int          miscompares;
    logic [31:0] model_c;

    mul dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .round_cfg (round_cfg),
        .flout_a   (flout_a),
        .flout_b   (flout_b),
        .flout_c   (flout_c)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stop the run if the main sequence never finishes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference multiply built from whole-number arithmetic.
    // The exact significand product is divided down to 24 bits. It is rounded by
    // comparing the remainder with one half of the discarded weight.
    function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b, input logic rc);
        logic            s;
        int              ea, eb, e, shift;
        logic [22:0]     fa, fb;
        bit              az, bz, ai, bi, an, bn;
        longint unsigned p, q, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (fa == 0);
        bi = (eb == 255) && (fb == 0);
        an = (ea == 255) && (fa != 0);
        bn = (eb == 255) && (fb != 0);
        if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC00000;
        if (ai || bi) return {s, 8'hFF, 23'd0};
        if (az || bz) return {s, 31'd0};
        p     = (64'h800000 | 64'(fa)) * (64'h800000 | 64'(fb));
        shift = (p >= (64'd1 << 47)) ? 24 : 23;
        e     = ea + eb - 127 + (shift - 23);
        q     = p >> shift;
        rem   = p - (q << shift);
        half  = 64'd1 << (shift - 1);
        if (!rc && ((rem > half) || ((rem == half) && q[0]))) q = q + 64'd1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return rc ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), q[22:0]};
    endfunction

    // Produce operands that cover normals over a wide exponent range, raw random words and special encodings.
    function automatic logic [31:0] randOperand();
        logic [31:0] specials [8];
        int          pick;
        specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                     32'h7FC00001, 32'h00000001, 32'h7F7FFFFF, 32'h00800000};
        pick = int'($urandom_range(0, 7));
        if (pick == 0) return $urandom;
        if (pick == 1) return specials[$urandom_range(0, 7)];
        if (pick < 5) return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        return {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
    endfunction

    // Drive one operand set at the falling edge.
    // Return just after the following rising edge so the result can be sampled.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic rc, input logic e);
        @(negedge clk);
        flout_a   = a;
        flout_b   = b;
        round_cfg = rc;
        en        = e;
        @(posedge clk);
        #1;
    endtask

    // Compare the registered result with the expected value.
    task automatic checkOutput(input string tag, input logic [31:0] expv);
        vectors++;
        assert (flout_c === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, flout_c, expv);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_c     = 32'h0;
        rst         = 1'b1;
        en          = 1'b0;
        round_cfg   = 1'b0;
        flout_a     = 32'h0;
        flout_b     = 32'h0;

        #1 rst = 1'b0;
        #2;
        checkOutput("reset_async", 32'h00000000);
        applyStimulus(32'h3FC00000, 32'h40000000, 1'b0, 1'b1);
        checkOutput("reset_hold_en", 32'h00000000);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;

        applyStimulus(32'h3FC00000, 32'h40000000, 1'b0, 1'b1);
        checkOutput("mul_1p5x2", 32'h40400000);
        applyStimulus(32'hC0000000, 32'h40400000, 1'b0, 1'b1);
        checkOutput("mul_neg2x3", 32'hC0C00000);
        applyStimulus(32'h3FC00001, 32'h3FC00001, 1'b0, 1'b1);
        checkOutput("round_rne", 32'h40100002);
        applyStimulus(32'h3FC00001, 32'h3FC00001, 1'b1, 1'b1);
        checkOutput("round_trunc", 32'h40100001);
        applyStimulus(32'h7F7FFFFF, 32'h40000000, 1'b0, 1'b1);
        checkOutput("ovf_rne_inf", 32'h7F800000);
        applyStimulus(32'h7F7FFFFF, 32'h40000000, 1'b1, 1'b1);
        checkOutput("ovf_trunc_max", 32'h7F7FFFFF);
        applyStimulus(32'hFF800000, 32'h3F800000, 1'b1, 1'b1);
        checkOutput("neg_inf", 32'hFF800000);
        applyStimulus(32'h7F800000, 32'h00000000, 1'b0, 1'b1);
        checkOutput("inf_x_zero", 32'h7FC00000);
        applyStimulus(32'h7FC00001, 32'h3F800000, 1'b0, 1'b1);
        checkOutput("nan_in", 32'h7FC00000);
        applyStimulus(32'h80000000, 32'h3F800000, 1'b0, 1'b1);
        checkOutput("neg_zero", 32'h80000000);
        applyStimulus(32'h00800000, 32'h3F000000, 1'b0, 1'b1);
        checkOutput("underflow_flush", 32'h00000000);
        applyStimulus(32'h00400000, 32'h7F000000, 1'b0, 1'b1);
        checkOutput("subnormal_zero", 32'h00000000);

        // Enable gating: with en low the result holds while the operands change.
        applyStimulus(32'h3FC00000, 32'h40000000, 1'b0, 1'b1);
        checkOutput("stream_load", 32'h40400000);
        applyStimulus(32'h40A00000, 32'h40A00000, 1'b0, 1'b0);
        checkOutput("stream_hold1", 32'h40400000);
        applyStimulus(32'hC0000000, 32'h7F800000, 1'b1, 1'b0);
        checkOutput("stream_hold2", 32'h40400000);
        applyStimulus(32'hC0000000, 32'h40400000, 1'b0, 1'b1);
        checkOutput("stream_resume", 32'hC0C00000);

        // Reset in the middle of the stream clears the result at once, regardless of en.
        @(negedge clk);
        flout_a = 32'h40A00000;
        flout_b = 32'h40A00000;
        en      = 1'b1;
        rst     = 1'b0;
        #1;
        checkOutput("midrst_async", 32'h00000000);
        @(posedge clk);
        #1;
        checkOutput("midrst_held", 32'h00000000);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        applyStimulus(32'h40A00000, 32'h40A00000, 1'b0, 1'b1);
        checkOutput("midrst_resume", 32'h41C80000);
        model_c = 32'h41C80000;

        // Randomized regression against the reference model, with en low about one cycle in eight.
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            logic        rrc, ren;
            ra  = randOperand();
            rb  = randOperand();
            rrc = 1'($urandom);
            ren = ($urandom_range(0, 7) != 0);
            if (ren) model_c = refMul(ra, rb, rrc);
            applyStimulus(ra, rb, rrc, ren);
            checkOutput("random", model_c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul.md
MUL -- requirements
Module: mul

Interface
REQ-001 Ports SHALL be: clk input 1 (rising-edge clock for all state).
REQ-002 Ports SHALL be: rst input 1 (asynchronous, active-low reset).
REQ-003 Ports SHALL be: en input 1 (result register update enable).
REQ-004 Ports SHALL be: round_cfg input 1 (0 = round-to-nearest-even, 1 = round-toward-zero/truncate).
REQ-005 Ports SHALL be: flout_a input 32 (IEEE-754 binary32 operand A: sign[31], exp[30:23], frac[22:0]).
REQ-006 Ports SHALL be: flout_b input 32 (IEEE-754 binary32 operand B, same format).
REQ-007 Ports SHALL be: flout_c output 32 (registered binary32 product A*B).
REQ-008 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low, on port rst.

Function
REQ-009 Latency SHALL be exactly 1 cycle: on a rising clk edge with en=1, flout_c SHALL take the product of the flout_a/flout_b/round_cfg values sampled at that edge.
REQ-010 With en=0, flout_c SHALL hold its value; there is no handshake, so a new operand pair is accepted every enabled cycle.
REQ-011 Sign: sign(c) = sign(a) XOR sign(b) for all results except NaN.
REQ-012 Normal path: 24x24 unsigned significand multiply (hidden 1 prepended) giving a 48-bit product; biased exp = ea + eb - 127, computed with at least 10 bits signed to detect over/underflow.
REQ-013 Normalization: if product bit 47 = 1, shift right 1 and increment exp; otherwise use bits [46:0].
REQ-014 Rounding (round_cfg=0): guard/round/sticky from discarded bits; round up if guard=1 and (round|sticky|lsb)=1 (ties to even).
REQ-015 Rounding (round_cfg=1): discard low bits, no increment.
REQ-016 Rounding carry-out of the significand SHALL renormalize (significand 1.0, exp+1) and SHALL be rechecked for overflow.
REQ-017 Overflow (final biased exp >= 255): round_cfg=0 -> signed infinity (exp=FF, frac=0); round_cfg=1 -> signed max finite (exp=FE, frac=7FFFFF).
REQ-018 Underflow (final biased exp <= 0): result SHALL flush to signed zero; no subnormal outputs are produced.
REQ-019 Subnormal inputs (exp=0, frac!=0) SHALL be treated as signed zero.
REQ-020 Any NaN input, or infinity times zero, SHALL give canonical quiet NaN 32'h7FC00000.
REQ-021 Infinity times nonzero finite or infinity SHALL give signed infinity; zero times finite SHALL give signed zero.
REQ-022 Special-case detection (REQ-019..021) SHALL take priority over the normal path; round_cfg does not affect special cases.

Reset
REQ-023 rst=0 SHALL asynchronously force flout_c to 32'h00000000, independent of clk and en.
REQ-024 While rst=0, flout_c SHALL stay 0; after release, the first rising clk edge with en=1 SHALL load a valid product. A product interrupted by reset is discarded.

Verification
REQ-025 a=3FC00000, b=40000000, en=1 -> flout_c=40400000 one cycle later; a=C0000000, b=40400000 -> C0C00000.
REQ-026 a=b=3FC00001: round_cfg=0 -> 40100002; round_cfg=1 -> 40100001.
REQ-027 a=7F7FFFFF, b=40000000: round_cfg=0 -> 7F800000; round_cfg=1 -> 7F7FFFFF; a=FF800000, b=3F800000 -> FF800000.
REQ-028 a=7F800000, b=00000000 -> 7FC00000; a=7FC00001, b=3F800000 -> 7FC00000; a=80000000, b=3F800000 -> 80000000; a=00800000, b=3F000000 -> 00000000 (flush).
REQ-029 Back-to-back stream with en toggling: on en=0 cycles flout_c holds its value; assert rst=0 mid-stream -> flout_c=0 immediately, then correct products resume on the first enabled edge after release.
REQ-030 Random regression: 1000 random operand pairs, one per cycle, compared against a reference binary32 multiply using the same flush-to-zero and NaN rules (REQ-018..021), with results aligned for the 1-cycle latency; zero mismatches required.
